// File: rtl/latch_sched_pkg.sv
// Shared types and helpers for the latch write scheduler: FSM state encoding and
// the phase-counter width calculation.
package latch_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_OPEN   = 3'd2,
    S_HOLD   = 3'd3,
    S_VERIFY = 3'd4
  } schedState_t;

  // Bits needed to count down from (longest phase - 1) to zero.
  function automatic int phaseWidth(input int setupCyc, input int openCyc, input int holdCyc);
    int longest;
    longest = setupCyc;
    if (openCyc > longest) longest = openCyc;
    if (holdCyc > longest) longest = holdCyc;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/latch_write_sched_if.sv
// Requester-side bus of the latch write scheduler: packed request/address/data
// vectors from the writers plus the one-hot grant and completion pulses.
interface latch_write_sched_if #(
  parameter int NREQ  = 4,
  parameter int AW    = 3,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;

  modport master (output req, req_addr, req_data, input gnt, done);
  modport slave  (input req, req_addr, req_data, output gnt, done);
endinterface

// File: rtl/latch_write_sched_arb.sv
// Combinational round-robin arbiter: first active request at or after the pointer
// wins, returned both as a one-hot vector and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] grantOh,
  output logic [PW-1:0]   grantIdx,
  output logic            anyReq
);

  int          cand;
  logic [PW-1:0] candIdx;

  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    cand     = 0;
    candIdx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(pointer) + k) % NREQ;
      candIdx = PW'(cand);
      if (!anyReq && req[candIdx]) begin
        anyReq            = 1'b1;
        grantIdx          = candIdx;
        grantOh[candIdx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_sched.sv
// Write sequencer for a bank of level-sensitive latches: round-robin capture, then
// setup/open/hold gate phasing. Optional readback check enabled by LATCH_READBACK_EN.
module latch_write_sched
  import latch_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int NLATCH    = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  latch_write_sched_if.slave   bus,
  output logic [WIDTH-1:0]     lat_d,
  output logic [NLATCH-1:0]    lat_en,
  output logic                 busy
`ifdef LATCH_READBACK_EN
  ,
  input  logic [NLATCH*WIDTH-1:0] lat_q,
  output logic                    err
`endif
);

  localparam int AW = (NLATCH > 1) ? $clog2(NLATCH) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = phaseWidth(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  schedState_t       stateReg, stateNext;
  logic [CW-1:0]     phaseReg, phaseNext;
  logic [PW-1:0]     ptrReg, ptrNext;
  logic [PW-1:0]     winnerReg;
  logic [AW-1:0]     addrReg;
  logic [WIDTH-1:0]  dataReg;
  logic [NREQ-1:0]   gntReg, doneReg;
  logic [NLATCH-1:0] latEnReg;
  logic [NLATCH-1:0] decEn;
  logic [NREQ-1:0]   winnerOneHot;
  logic              capture, finish;

  logic [NREQ-1:0]   arbGrant;
  logic [PW-1:0]     arbIndex;
  logic              arbValid;
  logic [AW-1:0]     selAddr;
  logic [WIDTH-1:0]  selData;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .req      (bus.req),
    .pointer  (ptrReg),
    .grantOh  (arbGrant),
    .grantIdx (arbIndex),
    .anyReq   (arbValid)
  );

  assign selAddr = bus.req_addr[int'(arbIndex)*AW +: AW];
  assign selData = bus.req_data[int'(arbIndex)*WIDTH +: WIDTH];
  assign ptrNext = (int'(arbIndex) == NREQ - 1) ? '0 : arbIndex + 1'b1;

  // Out-of-range addresses match no decoder output, so the gate stays low for them.
  for (genvar gi = 0; gi < NLATCH; gi++) begin : gDec
    assign decEn[gi] = (addrReg == AW'(gi));
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : gWin
    assign winnerOneHot[gi] = (winnerReg == PW'(gi));
  end

  always_comb begin
    stateNext = stateReg;
    phaseNext = phaseReg;
    capture   = 1'b0;
    finish    = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (arbValid) begin
          stateNext = S_SETUP;
          phaseNext = CW'(SETUP_CYC - 1);
          capture   = 1'b1;
        end
      end
      S_SETUP: begin
        if (phaseReg == '0) begin
          stateNext = S_OPEN;
          phaseNext = CW'(OPEN_CYC - 1);
        end else begin
          phaseNext = phaseReg - 1'b1;
        end
      end
      S_OPEN: begin
        if (phaseReg == '0) begin
          stateNext = S_HOLD;
          phaseNext = CW'(HOLD_CYC - 1);
        end else begin
          phaseNext = phaseReg - 1'b1;
        end
      end
      S_HOLD: begin
        if (phaseReg == '0) begin
`ifdef LATCH_READBACK_EN
          stateNext = S_VERIFY;
          phaseNext = '0;
`else
          stateNext = S_IDLE;
          finish    = 1'b1;
`endif
        end else begin
          phaseNext = phaseReg - 1'b1;
        end
      end
`ifdef LATCH_READBACK_EN
      S_VERIFY: begin
        stateNext = S_IDLE;
        finish    = 1'b1;
      end
`endif
      default: stateNext = S_IDLE;
    endcase
  end

  // Gate is registered from the next state so it rises and falls exactly on phase edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg  <= S_IDLE;
      phaseReg  <= '0;
      ptrReg    <= '0;
      winnerReg <= '0;
      addrReg   <= '0;
      dataReg   <= '0;
      gntReg    <= '0;
      doneReg   <= '0;
      latEnReg  <= '0;
    end else begin
      stateReg <= stateNext;
      phaseReg <= phaseNext;
      gntReg   <= capture ? arbGrant : '0;
      doneReg  <= finish ? winnerOneHot : '0;
      latEnReg <= (stateNext == S_OPEN) ? decEn : '0;
      if (capture) begin
        ptrReg    <= ptrNext;
        winnerReg <= arbIndex;
        addrReg   <= selAddr;
        dataReg   <= selData;
      end
    end
  end

`ifdef LATCH_READBACK_EN
  logic [WIDTH-1:0] readWord;
  logic             errReg;

  always_comb begin
    readWord = '0;
    for (int i = 0; i < NLATCH; i++) begin
      if (decEn[i]) readWord = readWord | lat_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      errReg <= 1'b0;
    end else if (stateReg == S_VERIFY && (|decEn) && readWord != dataReg) begin
      errReg <= 1'b1;
    end
  end

  assign err = errReg;
`endif

  assign bus.gnt  = gntReg;
  assign bus.done = doneReg;
  assign lat_d    = dataReg;
  assign lat_en   = latEnReg;
  assign busy     = (stateReg != S_IDLE);

endmodule

// File: tb/tb_latch_write_sched.sv
// Bench for latch_write_sched: a default DUT and a slow-phase, 6-word DUT checked every
// cycle against a write-level timeline model. LATCH_READBACK_EN adds the readback scenario.
module tb_latch_write_sched;

  localparam int S0 = 1, O0 = 1, H0 = 1, NL0 = 8;
  localparam int S1 = 2, O1 = 3, H1 = 2, NL1 = 6;
`ifdef LATCH_READBACK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]   rqV [2];
  logic [11:0]  adV [2];
  logic [127:0] dtV [2];

  latch_write_sched_if #(.NREQ(4), .AW(3), .WIDTH(32)) bus0 ();
  latch_write_sched_if #(.NREQ(4), .AW(3), .WIDTH(32)) bus1 ();

  assign bus0.req = rqV[0];
  assign bus0.req_addr = adV[0];
  assign bus0.req_data = dtV[0];
  assign bus1.req = rqV[1];
  assign bus1.req_addr = adV[1];
  assign bus1.req_data = dtV[1];

  logic [31:0] latD0, latD1;
  logic [7:0]  latEn0;
  logic [5:0]  latEn1;
  logic        busy0, busy1;

`ifdef LATCH_READBACK_EN
  logic [255:0] latQ0 = '0;
  logic [191:0] latQ1 = '0;
  logic         err0, err1;
  logic         forceZero0 = 1'b0;

  // Behavioural latch bank: transparent while its gate is high; word 3 of bank 0 can be stuck at 0.
  always @(negedge clock) begin
    for (int i = 0; i < 8; i++)
      if (latEn0[i] && !(forceZero0 && i == 3)) latQ0[i*32 +: 32] <= latD0;
    if (forceZero0) latQ0[96 +: 32] <= 32'h0;
    for (int i = 0; i < 6; i++)
      if (latEn1[i]) latQ1[i*32 +: 32] <= latD1;
  end
`endif

  latch_write_sched #(.NREQ(4), .WIDTH(32), .NLATCH(NL0),
                      .SETUP_CYC(S0), .OPEN_CYC(O0), .HOLD_CYC(H0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0.slave),
    .lat_d(latD0), .lat_en(latEn0), .busy(busy0)
`ifdef LATCH_READBACK_EN
    , .lat_q(latQ0), .err(err0)
`endif
  );

  latch_write_sched #(.NREQ(4), .WIDTH(32), .NLATCH(NL1),
                      .SETUP_CYC(S1), .OPEN_CYC(O1), .HOLD_CYC(H1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave),
    .lat_d(latD1), .lat_en(latEn1), .busy(busy1)
`ifdef LATCH_READBACK_EN
    , .lat_q(latQ1), .err(err1)
`endif
  );

  logic [48:0] obs0, obs1;
  assign obs0 = {bus0.gnt, bus0.done, latEn0, busy0, latD0};
  assign obs1 = {bus1.gnt, bus1.done, 2'b00, latEn1, busy1, latD1};

  int vectors = 0;
  int miscompares = 0;

  // Write-level model: mT = cycles since the visible grant (-1 when no write in flight).
  int          mT [2];
  int          mW [2];
  int          mAddr [2];
  int          mPtr [2];
  logic [31:0] mData [2];

  function automatic int lenOf(input int d);
    return (d == 0) ? (S0 + O0 + H0 + EXTRA) : (S1 + O1 + H1 + EXTRA);
  endfunction

  function automatic logic [48:0] expOf(input int d);
    logic [3:0] g, dn;
    logic [7:0] en;
    logic       b;
    int         s, o, nl;
    s  = (d == 0) ? S0 : S1;
    o  = (d == 0) ? O0 : O1;
    nl = (d == 0) ? NL0 : NL1;
    g = '0; dn = '0; en = '0;
    if (mT[d] == 0) g[mW[d]] = 1'b1;
    if (mT[d] == lenOf(d)) dn[mW[d]] = 1'b1;
    if (mT[d] >= s && mT[d] < s + o && mAddr[d] < nl) en[mAddr[d]] = 1'b1;
    b = (mT[d] >= 0 && mT[d] < lenOf(d));
    return {g, dn, en, b, mData[d]};
  endfunction

  task automatic modelStep(input int d);
    bit found;
    int c;
    if (mT[d] >= 0 && mT[d] < lenOf(d)) begin
      mT[d]++;
    end else begin
      mT[d] = -1;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = (mPtr[d] + k) % 4;
        if (!found && rqV[d][c]) begin
          found    = 1'b1;
          mT[d]    = 0;
          mW[d]    = c;
          mAddr[d] = int'(adV[d][c*3 +: 3]);
          mData[d] = dtV[d][c*32 +: 32];
          mPtr[d]  = (c + 1) % 4;
        end
      end
    end
  endtask

  task automatic endCycle();
    modelStep(0);
    modelStep(1);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mT[d] = -1; mW[d] = 0; mAddr[d] = 0; mPtr[d] = 0; mData[d] = '0;
    end
  endtask

  task automatic resetAll();
    @(negedge clock);
    reset_n = 1'b0;
    rqV[0] = '0;
    rqV[1] = '0;
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic newReq(input int d, input int i);
    rqV[d][i] = 1'b1;
    adV[d][i*3 +: 3] = 3'($urandom_range(7, 0));
    dtV[d][i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    resetAll();
    vectors++;
    if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
      miscompares++;
      $display("FAIL reset_state: got %h %h expected %h %h", obs0, obs1, expOf(0), expOf(1));
    end
`ifdef LATCH_READBACK_EN
    vectors++;
    if ({err0, err1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_err: got %b expected 00", {err0, err1});
    end
`endif
    endCycle();
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      endCycle();
    end
  endtask

  task automatic test_single_write();
    int gAt, dAt, enAt, enCnt;
    gAt = -100; dAt = -1; enAt = -1; enCnt = 0;
    resetAll();
    rqV[0] = 4'b0100;
    adV[0][6 +: 3] = 3'd5;
    dtV[0][64 +: 32] = 32'hDEADBEEF;
    endCycle();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL single_write cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (bus0.gnt[2]) gAt = n;
      if (bus0.done[2]) dAt = n;
      if (latEn0 == 8'h20) begin
        if (enAt < 0) enAt = n;
        enCnt++;
      end
      if (mT[0] == 0) rqV[0] = '0;
      endCycle();
    end
    vectors++;
    if (dAt - gAt !== lenOf(0)) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected %0d", dAt - gAt, lenOf(0));
    end
    vectors++;
    if (enCnt !== 1 || enAt - gAt !== 1) begin
      miscompares++;
      $display("FAIL single_gate: got count %0d offset %0d expected count 1 offset 1", enCnt, enAt - gAt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5];
    logic [3:0] seen [$];
    order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    resetAll();
    rqV[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      adV[0][i*3 +: 3] = 3'(2 * i + 1);
      dtV[0][i*32 +: 32] = $urandom;
    end
    endCycle();
    for (int n = 0; n < 22; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL round_robin cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (bus0.gnt != 4'h0) seen.push_back(bus0.gnt);
      endCycle();
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (k >= seen.size() || seen[k] !== order[k]) begin
        miscompares++;
        $display("FAIL rr_order %0d: got %h expected %h", k, (k < seen.size()) ? seen[k] : 4'h0, order[k]);
      end
    end
    rqV[0] = '0;
  endtask

  task automatic test_reset_mid_open();
    bit hit;
    logic [3:0] firstGnt;
    hit = 1'b0;
    firstGnt = '0;
    resetAll();
    rqV[0] = 4'b0010;
    adV[0][3 +: 3] = 3'd6;
    dtV[0][32 +: 32] = $urandom;
    endCycle();
    for (int n = 0; n < 6 && !hit; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL mid_open_pre cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (mT[0] == 0) rqV[0] = '0;
      if (mT[0] == 1) hit = 1'b1;
      else endCycle();
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (latEn0 !== 8'h00 || busy0 !== 1'b0 || bus0.done !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_open_reset: got en %h busy %b done %h expected 00 0 0", latEn0, busy0, bus0.done);
    end
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    endCycle();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL mid_open_post cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (bus0.gnt != 4'h0 && firstGnt == 4'h0) firstGnt = bus0.gnt;
      rqV[0] = (n == 3) ? 4'hF : 4'h0;
      endCycle();
    end
    vectors++;
    if (firstGnt !== 4'h1) begin
      miscompares++;
      $display("FAIL mid_open_pointer: got %h expected 1", firstGnt);
    end
  endtask

  task automatic test_phase_timing();
    int gAt, dAt, enAt, enCnt;
    gAt = -100; dAt = -1; enAt = -1; enCnt = 0;
    resetAll();
    rqV[1] = 4'b0001;
    adV[1][0 +: 3] = 3'd4;
    dtV[1][0 +: 32] = $urandom;
    endCycle();
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL phase_timing cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (bus1.gnt[0]) gAt = n;
      if (bus1.done[0]) dAt = n;
      if (latEn1 == 6'h10) begin
        if (enAt < 0) enAt = n;
        enCnt++;
      end
      if (mT[1] == 0) rqV[1] = '0;
      endCycle();
    end
    vectors++;
    if (enCnt !== 3 || enAt - gAt !== 2) begin
      miscompares++;
      $display("FAIL phase_gate: got count %0d offset %0d expected count 3 offset 2", enCnt, enAt - gAt);
    end
    vectors++;
    if (dAt - gAt !== 7 + EXTRA) begin
      miscompares++;
      $display("FAIL phase_latency: got %0d expected %0d", dAt - gAt, 7 + EXTRA);
    end
  endtask

  task automatic test_out_of_range();
    int gAt, dAt;
    logic [5:0] enSeen;
    gAt = -100; dAt = -1; enSeen = '0;
    resetAll();
    rqV[1] = 4'b1000;
    adV[1][9 +: 3] = 3'd7;
    dtV[1][96 +: 32] = $urandom;
    endCycle();
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL out_of_range cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      if (bus1.gnt[3]) gAt = n;
      if (bus1.done[3]) dAt = n;
      enSeen = enSeen | latEn1;
      if (mT[1] == 0) rqV[1] = '0;
      endCycle();
    end
    vectors++;
    if (enSeen !== 6'h00 || dAt - gAt !== lenOf(1)) begin
      miscompares++;
      $display("FAIL oor_write: got en %h latency %0d expected en 00 latency %0d", enSeen, dAt - gAt, lenOf(1));
    end
`ifdef LATCH_READBACK_EN
    vectors++;
    if (err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_err: got %b expected 0", err1);
    end
`endif
  endtask

  task automatic test_random();
    resetAll();
    endCycle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (mT[d] == 0 && mW[d] == i) begin
            if ($urandom_range(1, 0) == 1) rqV[d][i] = 1'b0;
            else newReq(d, i);
          end else if (!rqV[d][i]) begin
            if ($urandom_range(9, 0) < 3) newReq(d, i);
          end else if ($urandom_range(19, 0) == 0) begin
            rqV[d][i] = 1'b0;
          end
        end
      end
      endCycle();
    end
`ifdef LATCH_READBACK_EN
    vectors++;
    if ({err0, err1} !== 2'b00) begin
      miscompares++;
      $display("FAIL random_err: got %b expected 00", {err0, err1});
    end
`endif
  endtask

`ifdef LATCH_READBACK_EN
  task automatic test_readback();
    logic errExp;
    errExp = 1'b0;
    resetAll();
    forceZero0 = 1'b1;
    rqV[0] = 4'b0001;
    adV[0][0 +: 3] = 3'd3;
    dtV[0][0 +: 32] = 32'h1;
    endCycle();
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (mT[0] == lenOf(0)) errExp = 1'b1;
      vectors++;
      if ({obs0, obs1} !== {expOf(0), expOf(1)}) begin
        miscompares++;
        $display("FAIL readback cyc %0d: got %h %h expected %h %h", n, obs0, obs1, expOf(0), expOf(1));
      end
      vectors++;
      if (err0 !== errExp) begin
        miscompares++;
        $display("FAIL readback_err cyc %0d: got %b expected %b", n, err0, errExp);
      end
      if (mT[0] == 0) rqV[0] = '0;
      endCycle();
    end
    resetAll();
    forceZero0 = 1'b0;
    vectors++;
    if (err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL readback_clear: got %b expected 0", err0);
    end
  endtask
`endif

  initial begin
    rqV[0] = '0; rqV[1] = '0;
    adV[0] = '0; adV[1] = '0;
    dtV[0] = '0; dtV[1] = '0;
    modelReset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_reset_mid_open();
    test_phase_timing();
    test_out_of_range();
    test_random();
`ifdef LATCH_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
